// File: rtl/debug_jam.sv
`timescale 1ns/1ps
// debug_jam: debug-mode controller that jams a programmable address sequence onto the memory bus
module debug_jam #(
  parameter int ADDR_W = 16,
  parameter int SEQ_DEPTH = 32,
  parameter logic [ADDR_W-1:0] DBG_BASE = 'h7000,
  parameter logic [ADDR_W-1:0] DBG_EXIT = 'h7FFF,
  parameter int NUM_BP = 2,
  parameter bit RESET_TO_DEBUG = 1'b1,
  localparam int SEQ_AW = $clog2(SEQ_DEPTH)
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     ADS_n,
  input  logic [7:0]               data,
  input  logic [ADDR_W-1:0]        cpu_addr,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     halt_req,
  input  logic                     halt_inst_en,
  input  logic                     step_mode,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic                     seq_we,
  input  logic [SEQ_AW-1:0]        seq_waddr,
  input  logic [7:0]               seq_wdata,
  output logic                     INDBG_n,
  output logic                     BAEN_n,
  output logic [SEQ_AW-1:0]        seq_idx,
  output logic [7:0]               entry_cnt
);
  typedef enum logic [1:0] {RUN, JAM, USER} state_t;
  function automatic logic [SEQ_DEPTH*8-1:0] ram_init();
    logic [SEQ_DEPTH*8-1:0] r;
    for (int i = 0; i < SEQ_DEPTH; i++) r[i*8 +: 8] = (i == SEQ_DEPTH-1) ? 8'h40 : {2'b00, 6'(i)};
    return r;
  endfunction
  localparam logic [SEQ_DEPTH*8-1:0] RAM_INIT = ram_init();
  // Power-up contents come from the initializer; RST deliberately leaves the RAM alone.
  logic [SEQ_DEPTH*8-1:0] ram = RAM_INIT;
  state_t state, state_nxt;
  logic [7:0] entry;
  logic [1:0] step_cnt;
  logic halt_pend, strobe, bp_hit, trig, enter, exit_hit, unused_ok;
  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) bp_hit = bp_hit | (bp_en[i] & (bp_addr[i*ADDR_W +: ADDR_W] == cpu_addr));
    entry = ram[seq_idx*8 +: 8];
    strobe = ~ADS_n;
    trig = halt_pend | (halt_inst_en & data[7]) | bp_hit | (step_cnt == 2'd2);
    enter = strobe & trig & (state == RUN);
    exit_hit = strobe & (state == USER) & (cpu_addr == DBG_EXIT);
    unused_ok = ^data[6:0];
  end
  always_ff @(posedge clk) state <= RST ? (RESET_TO_DEBUG ? JAM : RUN) : state_nxt;
  always_comb state_nxt = enter ? JAM : exit_hit ? RUN : (strobe && state == JAM && entry[6]) ? USER : state;
  always_comb begin
    INDBG_n = state == RUN;
    BAEN_n = state == JAM;
    mem_addr = (state == JAM) ? (DBG_BASE | ADDR_W'(entry[5:0])) : cpu_addr;
  end
  // step_cnt: 0 idle, 1 armed, 2 first RUN cycle passed so the next strobe traps
  always_ff @(posedge clk) begin
    if (RST) begin
      seq_idx <= '0;
      halt_pend <= 1'b0;
      step_cnt <= 2'd0;
      entry_cnt <= 8'd0;
    end else begin
      halt_pend <= halt_req | (halt_pend & ~enter);
      if (enter) begin
        seq_idx <= '0;
        step_cnt <= 2'd0;
        entry_cnt <= (entry_cnt == 8'hFF) ? entry_cnt : entry_cnt + 8'd1;
      end else if (strobe && state == JAM) seq_idx <= entry[7] ? '0 : seq_idx + SEQ_AW'(1);
      else if (exit_hit) step_cnt <= {1'b0, step_mode};
      else if (strobe && state == RUN && step_cnt == 2'd1) step_cnt <= 2'd2;
    end
  end
  always_ff @(posedge clk) if (seq_we) ram[seq_waddr*8 +: 8] <= seq_wdata;
endmodule

// File: tb/tb_debug_jam.sv
`timescale 1ns/1ps
// tb_debug_jam: scenario tasks plus a randomized soak, all checked against a bus-cycle model
module tb_debug_jam;
  logic clk = 1'b0, RST, ADS_n, halt_req, halt_inst_en, step_mode, seq_we, INDBG_n, BAEN_n;
  logic [7:0] data, seq_wdata, entry_cnt;
  logic [15:0] cpu_addr, mem_addr;
  logic [1:0] bp_en;
  logic [31:0] bp_addr;
  logic [4:0] seq_waddr, seq_idx;
  int checks = 0, fails = 0;
  typedef enum int {M_RUN, M_JAM, M_USER} mode_t;
  mode_t m_mode;
  int m_idx, m_passed, m_cnt;
  bit m_halt;
  logic [7:0] m_ram [32];

  debug_jam dut (.clk(clk), .RST(RST), .ADS_n(ADS_n), .data(data), .cpu_addr(cpu_addr), .mem_addr(mem_addr),
    .halt_req(halt_req), .halt_inst_en(halt_inst_en), .step_mode(step_mode), .bp_en(bp_en), .bp_addr(bp_addr),
    .seq_we(seq_we), .seq_waddr(seq_waddr), .seq_wdata(seq_wdata), .INDBG_n(INDBG_n), .BAEN_n(BAEN_n),
    .seq_idx(seq_idx), .entry_cnt(entry_cnt));

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_mem(input logic [15:0] a);
    return (m_mode == M_JAM) ? (16'h7000 | {10'd0, m_ram[m_idx][5:0]}) : a;
  endfunction

  task automatic model_reset();
    m_mode = M_JAM; m_idx = 0; m_halt = 0; m_passed = -1; m_cnt = 0;
  endtask

  // One bus cycle as seen from the outside: who traps, where the jam pointer goes, when debug ends.
  task automatic model_strobe(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] e;
    case (m_mode)
      M_RUN:
        if (m_halt || (halt_inst_en && d[7]) || (bp_en[0] && bp_addr[15:0] == a) ||
            (bp_en[1] && bp_addr[31:16] == a) || m_passed == 1) begin
          m_mode = M_JAM; m_idx = 0; m_passed = -1; m_halt = 0;
          if (m_cnt < 255) m_cnt++;
        end else if (m_passed == 0) m_passed = 1;
      M_JAM: begin
        e = m_ram[m_idx];
        m_idx = e[7] ? 0 : (m_idx + 1) % 32;
        if (e[6]) m_mode = M_USER;
      end
      default:
        if (a == 16'h7FFF) begin
          m_mode = M_RUN;
          m_passed = step_mode ? 0 : -1;
        end
    endcase
    if (halt_req) m_halt = 1;
  endtask

  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); ADS_n = 0; cpu_addr = a; data = d; halt_req = 0; seq_we = 0; #1;
  endtask

  task automatic idle();
    @(negedge clk); ADS_n = 1; data = 0; halt_req = 0; seq_we = 0; #1;
  endtask

  task automatic advance(input logic [15:0] a);
    strobe(a, 8'h00); model_strobe(a, 8'h00); idle();
  endtask

  task automatic to_user();
    for (int k = 0; k < 100 && m_mode == M_JAM; k++) advance(16'($urandom));
  endtask

  task automatic write_seq(input int i, input logic [7:0] v);
    @(negedge clk); ADS_n = 1; seq_we = 1; seq_waddr = 5'(i); seq_wdata = v;
    @(negedge clk); seq_we = 0; m_ram[i] = v; #1;
  endtask

  task automatic do_reset();
    @(negedge clk); RST = 1; ADS_n = 1;
    @(negedge clk); @(negedge clk); RST = 0; model_reset(); #1;
  endtask

  task automatic pulse_halt();
    @(negedge clk); ADS_n = 1; halt_req = 1;
    @(negedge clk); halt_req = 0; m_halt = 1; #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (INDBG_n !== 1'b0) begin fails++; $display("FAIL reset_indbg: got %b expected 0", INDBG_n); end
    checks++; if (BAEN_n !== 1'b1) begin fails++; $display("FAIL reset_baen: got %b expected 1", BAEN_n); end
    checks++; if (mem_addr !== 16'h7000) begin fails++; $display("FAIL reset_mem: got %h expected 7000", mem_addr); end
    checks++; if (seq_idx !== 5'd0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", seq_idx); end
    checks++; if (entry_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", entry_cnt); end
  endtask

  task automatic test_default_seq();
    logic [15:0] a, e;
    for (int i = 0; i < 32; i++) begin
      a = 16'($urandom);
      e = (i == 31) ? 16'h7000 : 16'h7000 + 16'(i);
      strobe(a, 8'($urandom));
      checks++; if (mem_addr !== e) begin fails++; $display("FAIL default_seq[%0d]: got %h expected %h", i, mem_addr, e); end
      model_strobe(a, data);
      idle();
    end
    a = 16'($urandom); cpu_addr = a; #1;
    checks++; if (mem_addr !== a || BAEN_n !== 1'b0 || INDBG_n !== 1'b0)
      begin fails++; $display("FAIL user_after_seq: got mem=%h baen=%b indbg=%b expected mem=%h baen=0 indbg=0", mem_addr, BAEN_n, INDBG_n, a); end
  endtask

  task automatic test_breakpoint();
    logic [15:0] a;
    advance(16'h7FFF);
    checks++; if (INDBG_n !== 1'b1) begin fails++; $display("FAIL exit_to_run: got INDBG_n=%b expected 1", INDBG_n); end
    bp_en = 2'b01; bp_addr = {16'hBEEF, 16'h1234};
    strobe(16'hBEEF, 8'h00);
    checks++; if (mem_addr !== 16'hBEEF) begin fails++; $display("FAIL bp_disabled_ch: got %h expected beef", mem_addr); end
    model_strobe(16'hBEEF, 8'h00); idle();
    strobe(16'h1234, 8'h00);
    checks++; if (mem_addr !== 16'h1234) begin fails++; $display("FAIL bp_trigger_cycle: got %h expected 1234", mem_addr); end
    model_strobe(16'h1234, 8'h00); idle();
    a = 16'($urandom); strobe(a, 8'h00);
    checks++; if (mem_addr !== 16'h7000) begin fails++; $display("FAIL bp_first_jam: got %h expected 7000", mem_addr); end
    checks++; if (entry_cnt !== 8'd1) begin fails++; $display("FAIL bp_entry_cnt: got %0d expected 1", entry_cnt); end
    model_strobe(a, 8'h00); idle();
    bp_en = 2'b00;
    to_user();
  endtask

  task automatic test_last();
    logic [15:0] exp_seq [4];
    logic [15:0] a;
    exp_seq = '{16'h7000, 16'h7001, 16'h7005, 16'h7000};
    write_seq(2, 8'h85);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); strobe(a, 8'h00);
      checks++; if (mem_addr !== exp_seq[i]) begin fails++; $display("FAIL last_seq[%0d]: got %h expected %h", i, mem_addr, exp_seq[i]); end
      model_strobe(a, 8'h00); idle();
      if (i == 2) begin
        checks++; if (seq_idx !== 5'd0) begin fails++; $display("FAIL last_wrap_idx: got %0d expected 0", seq_idx); end
      end
    end
    write_seq(2, 8'h02);
    to_user();
  endtask

  task automatic test_step();
    step_mode = 1;
    strobe(16'h7FFF, 8'h00);
    checks++; if (mem_addr !== 16'h7FFF) begin fails++; $display("FAIL step_exit: got %h expected 7fff", mem_addr); end
    model_strobe(16'h7FFF, 8'h00); idle();
    step_mode = 0;
    strobe(16'h0100, 8'h00);
    checks++; if (mem_addr !== 16'h0100 || INDBG_n !== 1'b1) begin fails++; $display("FAIL step_first: got mem=%h indbg=%b expected mem=0100 indbg=1", mem_addr, INDBG_n); end
    model_strobe(16'h0100, 8'h00); idle();
    strobe(16'h0101, 8'h00);
    checks++; if (mem_addr !== 16'h0101) begin fails++; $display("FAIL step_second: got %h expected 0101", mem_addr); end
    model_strobe(16'h0101, 8'h00); idle();
    strobe(16'h0102, 8'h00);
    checks++; if (mem_addr !== 16'h7000 || BAEN_n !== 1'b1) begin fails++; $display("FAIL step_jam: got mem=%h baen=%b expected mem=7000 baen=1", mem_addr, BAEN_n); end
    model_strobe(16'h0102, 8'h00); idle();
    to_user();
  endtask

  task automatic test_halt();
    logic [15:0] a;
    pulse_halt();
    strobe(16'h4444, 8'h00);
    checks++; if (mem_addr !== 16'h4444 || INDBG_n !== 1'b0) begin fails++; $display("FAIL halt_in_user: got mem=%h indbg=%b expected mem=4444 indbg=0", mem_addr, INDBG_n); end
    model_strobe(16'h4444, 8'h00); idle();
    advance(16'h7FFF);
    strobe(16'h0200, 8'h00);
    checks++; if (mem_addr !== 16'h0200) begin fails++; $display("FAIL halt_trigger_cycle: got %h expected 0200", mem_addr); end
    model_strobe(16'h0200, 8'h00); idle();
    checks++; if (BAEN_n !== 1'b1) begin fails++; $display("FAIL halt_entered_jam: got %b expected 1", BAEN_n); end
    repeat (9) advance(16'($urandom));
    checks++; if (seq_idx !== 5'd9) begin fails++; $display("FAIL halt_idx9: got %0d expected 9", seq_idx); end
    do_reset();
    checks++; if (seq_idx !== 5'd0) begin fails++; $display("FAIL midjam_reset_idx: got %0d expected 0", seq_idx); end
    a = 16'($urandom); strobe(a, 8'h00);
    checks++; if (mem_addr !== 16'h7000) begin fails++; $display("FAIL midjam_reset_mem: got %h expected 7000", mem_addr); end
    model_strobe(a, 8'h00); idle();
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0] d;
    int r;
    bp_addr = {16'($urandom), 16'($urandom)};
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 7);
      a = (r < 2) ? 16'h7FFF : (r == 2) ? bp_addr[15:0] : (r == 3) ? bp_addr[31:16] : 16'($urandom);
      d = 8'($urandom);
      strobe(a, d);
      halt_inst_en = ($urandom_range(0, 3) == 0);
      bp_en = 2'($urandom);
      step_mode = 1'($urandom);
      halt_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        seq_we = 1; seq_waddr = 5'($urandom); seq_wdata = 8'($urandom);
      end
      checks++; if (mem_addr !== exp_mem(a)) begin fails++; $display("FAIL rand_mem[%0d]: got %h expected %h", n, mem_addr, exp_mem(a)); end
      checks++; if (BAEN_n !== (m_mode == M_JAM) || INDBG_n !== (m_mode == M_RUN))
        begin fails++; $display("FAIL rand_flags[%0d]: got baen=%b indbg=%b expected baen=%b indbg=%b", n, BAEN_n, INDBG_n, m_mode == M_JAM, m_mode == M_RUN); end
      model_strobe(a, d);
      if (seq_we) m_ram[seq_waddr] = seq_wdata;
      if ($urandom_range(0, 1) == 0) begin
        idle();
        checks++; if (seq_idx !== 5'(m_idx) || entry_cnt !== 8'(m_cnt))
          begin fails++; $display("FAIL rand_state[%0d]: got idx=%0d cnt=%0d expected idx=%0d cnt=%0d", n, seq_idx, entry_cnt, m_idx, m_cnt); end
      end
    end
    idle();
  endtask

  task automatic test_saturate();
    int e;
    halt_inst_en = 1; bp_en = 2'b00; step_mode = 0;
    write_seq(0, 8'h40);
    do_reset();
    for (int k = 0; k < 260; k++) begin
      advance(16'h0000);
      advance(16'h7FFF);
      strobe(16'h0100, 8'h80); model_strobe(16'h0100, 8'h80); idle();
      e = (k + 1 > 255) ? 255 : k + 1;
      checks++; if (entry_cnt !== 8'(e)) begin fails++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, entry_cnt, e); end
    end
  endtask

  initial begin
    RST = 1; ADS_n = 1; data = 0; cpu_addr = 0; halt_req = 0; halt_inst_en = 0; step_mode = 0;
    bp_en = 0; bp_addr = 0; seq_we = 0; seq_waddr = 0; seq_wdata = 0;
    for (int i = 0; i < 32; i++) m_ram[i] = (i == 31) ? 8'h40 : 8'(i);
    model_reset();
    test_reset();
    test_default_seq();
    test_breakpoint();
    test_last();
    test_step();
    test_halt();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/debug_jam.md
DEBUG_JAM -- requirements
Module: debug_jam

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, bus address width (>=8).
REQ-002 SHALL have parameter SEQ_DEPTH, default 32, jam-sequence entries (power of 2, 4..256); SEQ_AW = log2(SEQ_DEPTH).
REQ-003 SHALL have parameter DBG_BASE, default 16'h7000, debug-ROM base address (ADDR_W bits).
REQ-004 SHALL have parameter DBG_EXIT, default 16'h7FFF, CPU address whose fetch ends debug.
REQ-005 SHALL have parameter NUM_BP, default 2, address-breakpoint channels (1..8).
REQ-006 SHALL have parameter RESET_TO_DEBUG, default 1, enter JAM out of reset when 1, RUN when 0.
REQ-007 SHALL have ports: clk  in  1  clock (all logic on rising edge); RST  in  1  synchronous active-high reset.
REQ-008 SHALL have ports: ADS_n  in  1  address strobe, low for one clk per bus cycle; data  in  8  data bus, bit7 = halt-instruction status at ADS.
REQ-009 SHALL have ports: cpu_addr  in  ADDR_W  CPU address; mem_addr  out  ADDR_W  memory address.
REQ-010 SHALL have ports: halt_req  in  1  debug request pulse; halt_inst_en  in  1  enable data[7] entry; step_mode  in  1  single-step.
REQ-011 SHALL have ports: bp_en  in  NUM_BP  per-channel enable; bp_addr  in  NUM_BP*ADDR_W  breakpoint addresses, channel i at [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have ports: seq_we  in  1; seq_waddr  in  SEQ_AW; seq_wdata  in  8  jam-sequence RAM write port.
REQ-013 SHALL have ports: INDBG_n  out  1  low in JAM/USER; BAEN_n  out  1  high while jamming; seq_idx  out  SEQ_AW; entry_cnt  out  8.

Function
REQ-014 Sequence RAM entry SHALL be {last, release, off[5:0]}; jam address = DBG_BASE | zero-extended off.
REQ-015 Sequence RAM SHALL power up with: entries 0..SEQ_DEPTH-2 = index (release=0,last=0), entry SEQ_DEPTH-1 = 8'h40.
REQ-016 Write SHALL take effect next clk; same-cycle read of written index returns old data.
REQ-017 FSM SHALL have states RUN, JAM, USER; "strobe" = ADS_n low in that clk.
REQ-018 mem_addr SHALL be combinational: jam address of entry seq_idx in JAM, else cpu_addr; BAEN_n = (state==JAM).
REQ-019 Trigger SHALL be: halt_pend, or strobe & halt_inst_en & data[7], or strobe & any enabled bp_addr[i]==cpu_addr, or step_due.
REQ-020 halt_pend SHALL set on halt_req, hold until entry to JAM, then clear; halt_req on entry clk re-sets it.
REQ-021 RUN: strobe with trigger SHALL move to JAM next clk, seq_idx=0; the triggering bus cycle is not jammed.
REQ-022 JAM: each strobe SHALL advance seq_idx by 1 mod SEQ_DEPTH (wrap allowed).
REQ-023 JAM: strobe with last=1 SHALL load seq_idx=0 instead, staying in JAM; last takes priority over increment.
REQ-024 JAM: strobe with release=1 SHALL move to USER next clk; if last and release both set, seq_idx=0 and USER.
REQ-025 USER: strobe with cpu_addr==DBG_EXIT SHALL move to RUN; if step_mode=1, arm step.
REQ-026 Step SHALL be: armed counter; first RUN strobe passes unjammed, second RUN strobe asserts step_due; arm clears on entry.
REQ-027 Breakpoint and data[7] triggers SHALL be ignored in JAM/USER; halt_req still latches.
REQ-028 entry_cnt SHALL increment on each RUN->JAM transition, saturating at 255.

Reset
REQ-029 RST SHALL set: state = JAM if RESET_TO_DEBUG else RUN, seq_idx=0, halt_pend=0, step arm=0, entry_cnt=0; RAM contents retained.
REQ-030 RST mid-sequence SHALL abandon sequence; first strobe after reset uses entry 0.
REQ-031 After reset, outputs SHALL be: INDBG_n=0, BAEN_n=1, mem_addr=DBG_BASE|entry0 off (defaults); RESET_TO_DEBUG=0 gives INDBG_n=1, BAEN_n=0, mem_addr=cpu_addr.

Verification
REQ-032 Reset, default RAM, 32 strobes -> mem_addr 7000..701E, 32nd strobe (entry 31=8'h40) -> USER, mem_addr=cpu_addr.
REQ-033 RUN, bp_en=01, bp_addr0=0x1234, strobe at 0x1234 -> that cycle mem_addr=0x1234, next strobe mem_addr=0x7000, entry_cnt=1.
REQ-034 Write entry 2=8'h85 (last), strobes -> 7000,7001,7005, then 7000 again, seq_idx=0.
REQ-035 USER, step_mode=1, strobe at 0x7FFF -> RUN; strobe 0x0100 passes; next strobe at 0x0101 passes, following strobe jammed to 0x7000.
REQ-036 halt_req pulse in USER -> no effect until RUN; first RUN strobe triggers JAM; RST asserted mid-JAM at seq_idx=9 -> seq_idx=0.
